// File: rtl/ctrl_pkg.sv
// Shared encodings for the control unit: FSM states, instruction classes,
// stack sub-ops, datapath select codes and the registered strobe bundle.
package ctrl_pkg;

    typedef enum logic [1:0] {
        StFetch  = 2'b00,
        StDecode = 2'b01,
        StExec   = 2'b10,
        StHalt   = 2'b11
    } state_e;

    // Instruction class, isr[15:14] (isr[15] = 1 is always a branch)
    localparam logic [1:0] CLS_ALU = 2'b00;
    localparam logic [1:0] CLS_STK = 2'b01;

    // Stack/control sub-ops, isr[13:11]
    localparam logic [2:0] SOP_PUSH  = 3'd0;
    localparam logic [2:0] SOP_POP   = 3'd1;
    localparam logic [2:0] SOP_PUSHI = 3'd2;
    localparam logic [2:0] SOP_RET   = 3'd3;
    localparam logic [2:0] SOP_HALT  = 3'd4;

    // Stack-pointer operation
    localparam logic [1:0] SPI_HOLD = 2'd0;
    localparam logic [1:0] SPI_INC  = 2'd1;
    localparam logic [1:0] SPI_DEC  = 2'd2;

    // Memory-input select
    localparam logic [1:0] MEMIN_X   = 2'd0;
    localparam logic [1:0] MEMIN_PC1 = 2'd1;
    localparam logic [1:0] MEMIN_IMM = 2'd2;

    typedef struct packed {
        logic       regw;
        logic       memw;
        logic [1:0] memin;
        logic       sflag;
        logic [1:0] spi;
        logic       pcin;
        logic       pci;
        logic       pc_en;
    } strobes_t;

    localparam strobes_t STROBES_IDLE = '{
        regw:  1'b0,
        memw:  1'b0,
        memin: MEMIN_X,
        sflag: 1'b0,
        spi:   SPI_HOLD,
        pcin:  1'b1,
        pci:   1'b0,
        pc_en: 1'b0
    };

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: instruction register -> EXEC strobes.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [15:0] isr,
    output strobes_t    strobes,
    output logic        is_halt
);

    // Operand fields are consumed by the datapath, not here
    logic unused_isr;
    assign unused_isr = ^isr[10:0];

    // Map class and sub-op to the strobe bundle; PC advances unless HALT
    always_comb begin
        strobes       = STROBES_IDLE;
        strobes.pc_en = 1'b1;
        is_halt       = 1'b0;
        if (isr[15]) begin
            // Branch condition is resolved in the datapath from isr[15:12]
            strobes.pcin = 1'b1;
            strobes.pci  = 1'b1;
        end else if (isr[15:14] == CLS_ALU) begin
            if (isr[13:11] != 3'b000) begin
                strobes.regw  = 1'b1;
                strobes.sflag = 1'b1;
            end
        end else if (isr[15:14] == CLS_STK) begin
            case (isr[13:11])
                SOP_PUSH: begin
                    strobes.memw  = 1'b1;
                    strobes.memin = MEMIN_X;
                    strobes.spi   = SPI_DEC;
                end
                SOP_POP: begin
                    strobes.regw = 1'b1;
                    strobes.spi  = SPI_INC;
                end
                SOP_PUSHI: begin
                    strobes.memw  = 1'b1;
                    strobes.memin = MEMIN_IMM;
                    strobes.spi   = SPI_DEC;
                end
                SOP_RET: begin
                    strobes.pcin = 1'b0;
                    strobes.spi  = SPI_INC;
                end
                SOP_HALT: begin
                    strobes.pc_en = 1'b0;
                    is_halt       = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ctrl_unit.sv
// Multi-cycle control unit: fetch over req/ack, decode, one EXEC cycle of
// datapath strobes, with fetch timeout, halt state and retired counter.
module ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned ICOUNT_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                imem_ack,
    input  logic [15:0]         imem_data,
    output logic                imem_req,
    output logic [15:0]         isr,
    output logic                regw,
    output logic                memw,
    output logic [1:0]          memin,
    output logic                sflag,
    output logic [1:0]          spi,
    output logic                pcin,
    output logic                pci,
    output logic                pc_en,
    output logic                halted,
    output logic                fault,
    output logic [ICOUNT_W-1:0] icount
);

    state_e                state_q, state_d;
    logic                  run_q;
    logic [15:0]           isr_q, isr_d;
    strobes_t              dec_q, dec_d;
    logic                  dec_halt_q, dec_halt_d;
    logic [ICOUNT_W-1:0]   icount_q, icount_d;
    logic                  fault_q, fault_d;
    logic [31:0]           tmo_q, tmo_d;
    strobes_t              dec_strobes;
    logic                  dec_is_halt;
    strobes_t              out;

    ctrl_decode u_decode (
        .isr     (isr_q),
        .strobes (dec_strobes),
        .is_halt (dec_is_halt)
    );

    // Keeps the request low while reset is held; fetch starts on the first clock after
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // State, instruction register, registered decode and counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StFetch;
            isr_q      <= 16'h0000;
            dec_q      <= STROBES_IDLE;
            dec_halt_q <= 1'b0;
            icount_q   <= '0;
            fault_q    <= 1'b0;
            tmo_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            isr_q      <= isr_d;
            dec_q      <= dec_d;
            dec_halt_q <= dec_halt_d;
            icount_q   <= icount_d;
            fault_q    <= fault_d;
            tmo_q      <= tmo_d;
        end
    end

    // Next-state logic: handshake, timeout, decode capture, retire
    always_comb begin
        state_d    = state_q;
        isr_d      = isr_q;
        dec_d      = dec_q;
        dec_halt_d = dec_halt_q;
        icount_d   = icount_q;
        fault_d    = fault_q;
        tmo_d      = tmo_q;
        case (state_q)
            StFetch: begin
                if (run_q) begin
                    if (imem_ack) begin
                        isr_d   = imem_data;
                        tmo_d   = 32'd0;
                        state_d = StDecode;
                    end else if (TIMEOUT != 0) begin
                        tmo_d = tmo_q + 32'd1;
                        if (tmo_d == TIMEOUT) begin
                            fault_d = 1'b1;
                            state_d = StHalt;
                        end
                    end
                end
            end
            StDecode: begin
                dec_d      = dec_strobes;
                dec_halt_d = dec_is_halt;
                state_d    = StExec;
            end
            StExec: begin
                icount_d = icount_q + ICOUNT_W'(1);
                state_d  = dec_halt_q ? StHalt : StFetch;
            end
            StHalt: ;
        endcase
    end

    // Outputs: strobes only in EXEC, request only in an active FETCH
    always_comb begin
        out      = STROBES_IDLE;
        imem_req = (state_q == StFetch) && run_q;
        halted   = (state_q == StHalt);
        if (state_q == StExec) begin
            out = dec_q;
        end
    end

    assign regw   = out.regw;
    assign memw   = out.memw;
    assign memin  = out.memin;
    assign sflag  = out.sflag;
    assign spi    = out.spi;
    assign pcin   = out.pcin;
    assign pci    = out.pci;
    assign pc_en  = out.pc_en;
    assign isr    = isr_q;
    assign fault  = fault_q;
    assign icount = icount_q;

endmodule

// File: tb/tb_ctrl_unit.sv
// Scoreboard bench for ctrl_unit: the driver pushes the expected EXEC strobes
// per fetched word; a monitor follows the handshake and checks each phase.
module tb_ctrl_unit;

    localparam int unsigned TMO = 4;
    localparam int unsigned ICW = 4;
    // {regw, memw, memin, sflag, spi, pcin, pci, pc_en}
    localparam logic [9:0] IDLE = 10'b00_0000_0100;

    typedef struct packed {
        logic       halt;
        logic [9:0] s;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           imem_ack = 1'b0;
    logic [15:0]    imem_data = 16'h0000;
    logic           imem_req;
    logic [15:0]    isr;
    logic           regw, memw, sflag, pcin, pci, pc_en, halted, fault;
    logic [1:0]     memin, spi;
    logic [ICW-1:0] icount;

    int   n_tests = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    int   exp_icount = 0;
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;

    ctrl_unit #(.TIMEOUT(TMO), .ICOUNT_W(ICW)) dut (
        .clk       (clk),
        .reset     (reset),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .imem_req  (imem_req),
        .isr       (isr),
        .regw      (regw),
        .memw      (memw),
        .memin     (memin),
        .sflag     (sflag),
        .spi       (spi),
        .pcin      (pcin),
        .pci       (pci),
        .pc_en     (pc_en),
        .halted    (halted),
        .fault     (fault),
        .icount    (icount)
    );

    function automatic logic [9:0] strobes();
        return {regw, memw, memin, sflag, spi, pcin, pci, pc_en};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: instruction semantics as listed for each mnemonic
    function automatic exp_t model(input logic [15:0] w);
        exp_t       e;
        logic       r_regw, r_memw, r_sflag, r_pcin, r_pci, r_pcen;
        logic [1:0] r_memin, r_spi;
        r_regw = 0; r_memw = 0; r_sflag = 0; r_pcin = 1; r_pci = 0; r_pcen = 1;
        r_memin = 0; r_spi = 0;
        e.halt = 1'b0;
        if (w[15]) begin
            r_pci = 1;                                       // branch
        end else if (!w[14]) begin
            if (w[13:11] != 0) begin r_regw = 1; r_sflag = 1; end
        end else begin
            case (w[13:11])
                3'd0: begin r_memw = 1; r_spi = 2; end                 // PUSH
                3'd1: begin r_regw = 1; r_spi = 1; end                 // POP
                3'd2: begin r_memw = 1; r_memin = 2; r_spi = 2; end    // PUSHI
                3'd3: begin r_pcin = 0; r_spi = 1; end                 // RET
                3'd4: begin r_pcen = 0; e.halt = 1'b1; end             // HALT
                default: ;
            endcase
        end
        e.s = {r_regw, r_memw, r_memin, r_sflag, r_spi, r_pcin, r_pci, r_pcen};
        return e;
    endfunction

    // Wait (bounded) for a request, withhold ack for 'waits' cycles, then deliver w
    task automatic issue(input logic [15:0] w, input int waits);
        int n;
        n = 0;
        while (!imem_req && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        if (!imem_req) begin
            n_tests++;
            n_fail++;
            $display("FAIL fetch_wait: got no imem_req within 50 cycles, expected a request");
            return;
        end
        imem_ack = 1'b0;
        repeat (waits) begin
            @(negedge clk); #1;
        end
        imem_ack  = 1'b1;
        imem_data = w;
        exp_q.push_back(model(w));
        @(negedge clk); #1;
        imem_ack  = 1'b0;
        imem_data = 16'($urandom);
    endtask

    task automatic assert_reset();
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk); #1;
        exp_q.delete();
        exp_icount = 0;
        reset  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk); #1;
        chk("req_restart", imem_req, 1);
    endtask

    // Monitor: handshake seen -> DECODE check -> EXEC pop/compare -> post-EXEC check
    initial begin : monitor
        int          phase;
        logic [15:0] word;
        exp_t        e;
        phase = 0;
        word  = 16'h0000;
        e     = '0;
        forever begin
            @(negedge clk); #2;
            if (!mon_en) begin
                phase = 0;
            end else if (phase == 1) begin
                chk("decode_idle", strobes(), IDLE);
                chk("decode_req", imem_req, 0);
                chk("isr", isr, word);
                phase = 2;
            end else if (phase == 2) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL exec_pop: got an EXEC cycle, expected an queued instruction");
                    e = '0;
                end else begin
                    e = exp_q.pop_front();
                    chk("exec_strobes", strobes(), e.s);
                    chk("exec_req", imem_req, 0);
                end
                exp_icount++;
                phase = 3;
            end else begin
                if (phase == 3) begin
                    chk("icount", icount, exp_icount % (1 << ICW));
                    if (e.halt) begin
                        chk("halted", halted, 1);
                        chk("halt_req", imem_req, 0);
                    end else begin
                        chk("refetch_req", imem_req, 1);
                        chk("not_halted", halted, 0);
                    end
                end
                phase = 0;
                chk("idle_strobes", strobes(), IDLE);
                if (imem_req && imem_ack) begin
                    phase = 1;
                    word  = imem_data;
                end
            end
        end
    end

    initial begin : driver
        logic [15:0] w;
        int          cnt;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_isr", isr, 0);
        chk("rst_icount", icount, 0);
        chk("rst_halted", halted, 0);
        chk("rst_fault", fault, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_strobes", strobes(), IDLE);
        release_reset();

        issue(16'h1500, 1);
        issue(16'h4300, 0);
        issue(16'h4900, 2);
        issue(16'h5800, 0);
        issue(16'h5005, 1);
        issue(16'h8FFE, 0);
        for (int i = 0; i < 40; i++) begin
            w = 16'($urandom);
            if (w[15:11] == 5'b01100) w[11] = 1'b1;
            issue(w, int'($urandom_range(0, 3)));
        end

        // HALT: no refetch, stray acks ignored, counter frozen
        issue(16'h6000, 0);
        repeat (2) begin
            @(negedge clk); #1;
        end
        for (int i = 0; i < 20; i++) begin
            imem_ack  = 1'b1;
            imem_data = 16'($urandom);
            @(negedge clk); #1;
            chk("halt_hold", halted, 1);
            chk("halt_no_req", imem_req, 0);
        end
        imem_ack = 1'b0;
        chk("halt_queue_empty", exp_q.size(), 0);
        chk("icount_frozen", icount, exp_icount % (1 << ICW));

        // Fetch timeout: exactly TMO request cycles, then fault + halt
        assert_reset();
        release_reset();
        cnt = 0;
        while (imem_req && cnt < 20) begin
            cnt++;
            @(negedge clk); #1;
        end
        chk("tmo_req_cycles", cnt, TMO);
        chk("tmo_fault", fault, 1);
        chk("tmo_halted", halted, 1);
        chk("tmo_isr", isr, 0);
        assert_reset();
        chk("rst_fault_clr", fault, 0);
        chk("rst_halted_clr", halted, 0);
        chk("rst_halt_req", imem_req, 0);
        release_reset();

        // Reset during DECODE
        issue(16'h1500, 0);
        assert_reset();
        chk("rst_dec_strobes", strobes(), IDLE);
        chk("rst_dec_req", imem_req, 0);
        chk("rst_dec_isr", isr, 0);
        release_reset();

        // Reset during EXEC: strobes drop immediately
        issue(16'h4300, 0);
        @(negedge clk); #1;
        chk("pre_rst_memw", memw, 1);
        assert_reset();
        chk("rst_exec_strobes", strobes(), IDLE);
        chk("rst_exec_icount", icount, 0);
        release_reset();

        for (int i = 0; i < 8; i++) begin
            w = 16'($urandom);
            if (w[15:11] == 5'b01100) w[11] = 1'b1;
            issue(w, int'($urandom_range(0, 3)));
        end
        repeat (4) begin
            @(negedge clk); #1;
        end
        chk("final_queue_empty", exp_q.size(), 0);
        chk("final_icount", icount, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_unit.md
Name: ctrl_unit

Overview:
- Multi-cycle control unit that drives the 16-bit accumulator/stack datapath.
- Fetches instruction words from instruction memory over a req/ack handshake and holds them in the instruction register, which it presents on isr.
- Decodes each instruction and emits one cycle of datapath strobes: regw, memw, memin, sflag, spi, pcin, pci and pc_en.
- pc_en is the PC load enable; the datapath PC updates only when pc_en is high.

Parameters:
- TIMEOUT, 255: maximum fetch wait in cycles. 0 disables the timeout.
- ICOUNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_ack  in  1  instruction memory acknowledge; imem_data is valid while high.
- imem_data  in  16  instruction word.
- imem_req  out  1  fetch request.
- isr  out  16  instruction register, to the datapath.
- regw  out  1  register-bank write strobe.
- memw  out  1  data-memory write strobe.
- memin  out  2  memory-input select: 0 = x, 1 = pc+1, 2 = sign-extended immediate.
- sflag  out  1  flag-register update strobe.
- spi  out  2  stack-pointer op: 0 = hold, 1 = increment, 2 = decrement.
- pcin  out  1  PC source: 0 = memory output (y), 1 = incrementer path.
- pci  out  1  PC mode: 0 = pc+1, 1 = conditional pc+1+offset.
- pc_en  out  1  PC load enable.
- halted  out  1  high in the HALT state.
- fault  out  1  fetch timeout occurred (sticky until reset).
- icount  out  ICOUNT_W  count of retired instructions.

Behaviour:
- States: FETCH, DECODE, EXEC, HALT. Encoding comes from the package.
- Reset (reset low, asynchronous): state = FETCH, isr = 0, icount = 0, halted = 0, fault = 0, timeout counter = 0. All outputs take their idle values.
- Idle values: imem_req = 0, regw = 0, memw = 0, sflag = 0, spi = 0, memin = 0, pcin = 1, pci = 0, pc_en = 0.
- Idle values hold in every state except EXEC and except imem_req in FETCH.
- FETCH:
  - imem_req = 1 each cycle until imem_ack is sampled high.
  - On that edge: isr <= imem_data, next state DECODE, imem_req drops the following cycle.
  - Minimum fetch is 1 cycle when ack is already high.
  - imem_ack seen outside FETCH is ignored.
- Timeout: the counter increments for each FETCH cycle without ack. When it reaches TIMEOUT (TIMEOUT != 0): fault = 1, go to HALT, isr unchanged.
- DECODE: 1 cycle, outputs idle; the decode result is registered.
- EXEC: 1 cycle with the decoded strobes, then FETCH. icount increments (wraps mod 2^ICOUNT_W). pc_en = 1 for every instruction except HALT.
- Decode of isr[15:14] = 00 (ALU; funsel isr[13:11], reg isr[10:8]):
  - funsel != 0: regw = 1, sflag = 1.
  - funsel = 0: NOP, no strobes.
- Decode of isr[15:14] = 01 (stack/control; sub-op isr[13:11]):
  - 000 PUSH: memw = 1, memin = 0, spi = 2.
  - 001 POP: regw = 1, spi = 1.
  - 010 PUSHI: memw = 1, memin = 2, spi = 2.
  - 011 RET: pcin = 0, spi = 1.
  - 100 HALT: pc_en = 0; next state HALT; icount still increments.
  - 101-111: NOP.
- Decode of isr[15] = 1 (branch): pcin = 1, pci = 1. The condition (isr[15:12]) is evaluated in the datapath; the control unit never reads flags.
- In all non-RET instructions pcin = 1.
- HALT: all outputs idle, halted = 1, imem_req = 0. Leaves only on reset.
- Reset mid-fetch or mid-EXEC aborts the instruction with no partial strobes after reset falls. Fetch restarts on the first clock after reset rises.

Decomposition:
- Shared package ctrl_pkg:
  - state encoding;
  - class constants CLS_ALU = 2'b00, CLS_STK = 2'b01;
  - stack sub-op constants SOP_PUSH/POP/PUSHI/RET/HALT;
  - spi codes SPI_HOLD/INC/DEC;
  - memin codes MEMIN_X/PC1/IMM.
- One combinational sub-module ctrl_decode: maps isr to the strobe bundle plus an is_halt flag. The top level holds the FSM, handshake, counters and the registered strobes.

Test Plan:
- Release reset, ack on 2nd request cycle with 0x1500 -> isr = 0x1500. Exactly one EXEC cycle with regw = 1, sflag = 1, pc_en = 1, memw = 0. Then icount = 1 and imem_req reasserts. Total fetch-to-fetch = 4 cycles.
- Fetch 0x4300 (PUSH r3) then 0x4900 (POP r1) -> EXEC1: memw = 1, memin = 0, spi = 2. EXEC2: regw = 1, spi = 1, memw = 0. icount = 2.
- Fetch 0x5800 (RET) -> EXEC: pcin = 0, spi = 1, pc_en = 1, regw = 0. Fetch 0x5005 (PUSHI 5) -> memw = 1, memin = 2, spi = 2.
- Fetch 0x8FFE (branch) -> EXEC: pcin = 1, pci = 1, pc_en = 1, no regw/memw/sflag.
- Fetch 0x6000 (HALT) -> EXEC with pc_en = 0, then halted = 1, imem_req stays 0 for 20 cycles, a stray imem_ack is ignored, icount frozen at N+1.
- TIMEOUT = 4, never ack -> after 4 request cycles fault = 1, halted = 1. Assert reset during DECODE of the next run -> all strobes idle immediately and fault/halted cleared.
